// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, controller states and small op-decoding helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10
    } state_e;

    // Odd op codes are the two's-complement variants
    function automatic logic opIsSigned(input op_e op);
        return op[0];
    endfunction

    function automatic logic opIsDivide(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage
// pipeline (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, dataA, dataB,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, dataA, dataB,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle.
// Operands become magnitudes on entry; signs are reapplied in FIXUP.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               r_state, w_nextState;
    op_e                  r_op, w_nextOp;
    logic [2*WIDTH-1:0]   r_acc, w_nextAcc;
    logic [WIDTH-1:0]     r_opB, w_nextOpB;
    logic [WIDTH-1:0]     r_hi, w_nextHi;
    logic [WIDTH-1:0]     r_lo, w_nextLo;
    logic [CW-1:0]        r_cnt, w_nextCnt;
    logic                 r_negA, w_nextNegA;
    logic                 r_negB, w_nextNegB;
    logic                 r_busy, w_nextBusy;
    logic                 r_done, w_nextDone;
    logic                 r_dbz, w_nextDbz;

    op_e                  w_reqOp;
    logic                 w_reqSigned;
    logic                 w_load;
    logic [WIDTH-1:0]     w_magA, w_magB;
    logic [WIDTH:0]       w_mulSum;
    logic [WIDTH:0]       w_divDiff;
    logic [2*WIDTH-1:0]   w_mulStep, w_divStep;
    logic [2*WIDTH-1:0]   w_prodSigned;
    logic [WIDTH-1:0]     w_quot, w_rem;

    assign w_reqOp     = op_e'(bus.op);
    assign w_reqSigned = opIsSigned(w_reqOp);
    assign w_magA      = (w_reqSigned && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
    assign w_magB      = (w_reqSigned && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;

    // A new op is accepted when idle or in the final cycle of the previous one
    assign w_load = bus.start && (r_state == ST_IDLE || r_state == ST_FIXUP);

    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opB} : '0);
    assign w_mulStep = {w_mulSum, r_acc[WIDTH-1:1]};

    // Restoring step: partial remainder shifted left with the next dividend bit
    assign w_divDiff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opB};
    assign w_divStep = w_divDiff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prodSigned = (r_negA ^ r_negB) ? -r_acc : r_acc;
    assign w_quot       = r_acc[WIDTH-1:0];
    assign w_rem        = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_nextState = r_state;
        w_nextOp    = r_op;
        w_nextAcc   = r_acc;
        w_nextOpB   = r_opB;
        w_nextHi    = r_hi;
        w_nextLo    = r_lo;
        w_nextCnt   = r_cnt;
        w_nextNegA  = r_negA;
        w_nextNegB  = r_negB;
        w_nextBusy  = r_busy;
        w_nextDone  = 1'b0;
        w_nextDbz   = r_dbz;

        case (r_state)
            ST_RUN: begin
                w_nextAcc = opIsDivide(r_op) ? w_divStep : w_mulStep;
                w_nextCnt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_nextState = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                w_nextState = ST_IDLE;
                w_nextBusy  = 1'b0;
                w_nextDone  = 1'b1;
                if (opIsDivide(r_op)) begin
                    w_nextDbz = (r_opB == '0);
                    w_nextHi  = r_negA ? -w_rem : w_rem;
                    if (r_opB == '0) begin
                        w_nextLo = '1;
                    end else begin
                        w_nextLo = (r_negA ^ r_negB) ? -w_quot : w_quot;
                    end
                end else begin
                    w_nextDbz = 1'b0;
                    {w_nextHi, w_nextLo} = w_prodSigned;
                end
            end
            default: begin
            end
        endcase

        if (w_load) begin
            w_nextState = ST_RUN;
            w_nextOp    = w_reqOp;
            w_nextAcc   = {{WIDTH{1'b0}}, w_magA};
            w_nextOpB   = w_magB;
            w_nextNegA  = w_reqSigned & bus.dataA[WIDTH-1];
            w_nextNegB  = w_reqSigned & bus.dataB[WIDTH-1];
            w_nextCnt   = CW'(WIDTH);
            w_nextBusy  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULTU;
            r_acc   <= '0;
            r_opB   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_negA  <= 1'b0;
            r_negB  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_op    <= w_nextOp;
            r_acc   <= w_nextAcc;
            r_opB   <= w_nextOpB;
            r_hi    <= w_nextHi;
            r_lo    <= w_nextLo;
            r_cnt   <= w_nextCnt;
            r_negA  <= w_nextNegA;
            r_negB  <= w_nextNegB;
            r_busy  <= w_nextBusy;
            r_done  <= w_nextDone;
            r_dbz   <= w_nextDbz;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit (WIDTH=32): expected
// results come from a plain-arithmetic reference model through a scoreboard.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dbz;
    } result_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    result_t sbQ[$];

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full-width arithmetic straight from the op definitions
    function automatic result_t refModel(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        result_t     r;
        logic [63:0] p;
        longint      sa, sb, q, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.dbz = 1'b0;
        case (op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                {r.hi, r.lo} = p;
            end
            2'b01: begin
                p = 64'(sa * sb);
                {r.hi, r.lo} = p;
            end
            default: begin
                if (b == 32'd0) begin
                    r.lo  = '1;
                    r.hi  = a;
                    r.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r.lo = q[31:0];
                    r.hi = m[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Issues one op; pulseAt>0 re-pulses start with junk operands mid-operation
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit checkTiming,
                                 input int pulseAt);
        int doneAt;
        int busyCycles;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.dataA = a;
        bus.dataB = b;
        sbQ.push_back(refModel(op, a, b));
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        doneAt     = 0;
        busyCycles = 0;
        for (int i = 1; i <= 100 && doneAt == 0; i++) begin
            if (bus.busy) busyCycles++;
            if (i == pulseAt) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.dataA = 32'd7;
                bus.dataB = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) doneAt = i;
        end
        bus.start = 1'b0;
        if (doneAt == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL doneTimeout: got no done expected done within 100 cycles");
        end else if (checkTiming) begin
            checkOutput("latency", 64'(doneAt), 64'(WIDTH + 1));
            checkOutput("busyCycles", 64'(busyCycles), 64'(WIDTH + 1));
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedDone: got done=1 expected no pending op");
            end else begin
                result_t exp;
                exp = sbQ.pop_front();
                checkOutput("hi", 64'(bus.hi), 64'(exp.hi));
                checkOutput("lo", 64'(bus.lo), 64'(exp.lo));
                checkOutput("divByZero", 64'(bus.div_by_zero), 64'(exp.dbz));
            end
        end
    end

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'(signed'(-$urandom_range(1, 50)));
            4:       return 32'($urandom_range(1, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.dataA = '0;
        bus.dataB = '0;
        #2 reset = 1'b1;
        #10;
        checkOutput("resetBusy", 64'(bus.busy), 64'd0);
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        checkOutput("resetHi", 64'(bus.hi), 64'd0);
        checkOutput("resetLo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(2'b00, 32'd15, 32'd10, 1'b1, 0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        applyStimulus(2'b10, 32'd1000, 32'd7, 1'b0, 0);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(2'b10, 32'd100, 32'd0, 1'b1, 0);
        applyStimulus(2'b00, 32'd3, 32'd3, 1'b0, 0);
        applyStimulus(2'b11, 32'hFFFF_FFF0, 32'd0, 1'b0, 0);
        applyStimulus(2'b00, 32'd20, 32'd30, 1'b0, 10);
        repeat (45) @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 1'b0, 0);
        end
        applyStimulus(2'b10, 32'd12345, 32'd100, 1'b0, 0);

        // Abort an op mid-RUN with an asynchronous reset between clock edges
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.dataA = 32'd77;
        bus.dataB = 32'd88;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("midResetBusy", 64'(bus.busy), 64'd0);
        checkOutput("midResetDone", 64'(bus.done), 64'd0);
        checkOutput("midResetHi", 64'(bus.hi), 64'd0);
        checkOutput("midResetLo", 64'(bus.lo), 64'd0);
        checkOutput("midResetDbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(2'b00, 32'd1000, 32'd1000, 1'b1, 0);

        repeat (40) @(posedge clk);
        checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit: the successor to the fixed 32-bit unsigned `Multiplier`. It executes signed and unsigned multiply and divide on WIDTH-bit operands, one bit per cycle, with an explicit start/busy/done handshake. Results land in HI/LO registers. It sits beside the ALU in the EX stage; the pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only while idle.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- dataA  in  WIDTH  multiplicand or dividend; sampled with start.
- dataB  in  WIDTH  multiplier or divisor; sampled with start.
- busy  out  1  operation in progress; start is ignored while high.
- done  out  1  one-cycle pulse; hi, lo and div_by_zero are valid from this cycle.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.
- div_by_zero  out  1  the last completed op was a DIV/DIVU with dataB = 0.

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE with start=1:
  - latch op and operands;
  - for signed ops, convert operands to magnitudes and record the result signs;
  - counter = WIDTH, busy = 1, go to RUN.
- IDLE with start=0: remain in IDLE.
- RUN: one shift-add step (multiply) or restoring shift-subtract step (divide) per cycle. Decrement counter. At counter = 1, go to FIXUP.
- FIXUP:
  - apply sign correction and write hi/lo;
  - done = 1, busy = 0;
  - set div_by_zero for the op;
  - go to IDLE.
- Multiply: {hi,lo} is the full 2·WIDTH-bit product.
  - MULT: two's-complement operands.
  - MULTU: unsigned operands.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo = all ones, hi = dataA, div_by_zero = 1. Full latency still applies; there is no early exit.
- DIV of MIN by −1: lo = MIN, hi = 0 (wraps), div_by_zero = 0.
- div_by_zero updates at every done; it is 0 for multiplies.
- start while busy: ignored, and operand or op changes have no effect.
- hi/lo hold their values until the next done.

## Timing
- Start sampled at edge t.
- busy is high from edge t to edge t+WIDTH+1.
- At edge t+WIDTH+1: hi/lo/div_by_zero update, done rises, busy falls.
- done falls at edge t+WIDTH+2.
- A new start can be sampled at edge t+WIDTH+1 (start held high continuously) or at any later edge. Back-to-back throughput is one op per WIDTH+1 cycles.
- Latency from the start edge to result valid: WIDTH+1 cycles (33 for WIDTH=32).
- Reset, asynchronous and effective at any time including mid-operation:
  - state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0;
  - any in-flight op is discarded.
- Reset released with start=1: start is sampled on the first rising edge with reset low.

## Structure
- Shared package mdu_pkg holds:
  - op codes: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state encodings: ST_IDLE, ST_RUN, ST_FIXUP.
- Single module; no sub-module warranted.
- Datapath: 2·WIDTH accumulator/remainder register, WIDTH operand register, clog2(WIDTH+1)-bit counter.

## Test plan
All cases use WIDTH=32.
- MULTU 15×10 → hi=0, lo=150; done exactly 33 cycles after the start edge; busy high for exactly 33 cycles.
- dataA=FFFFFFFF, dataB=2:
  - MULT → hi=FFFFFFFF, lo=FFFFFFFE;
  - MULTU → hi=00000001, lo=FFFFFFFE.
- Signed and unsigned divide:
  - DIV −7/2 → lo=FFFFFFFD, hi=FFFFFFFF;
  - DIVU 1000/7 → lo=142, hi=6;
  - DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIVU 100/0 → lo=FFFFFFFF, hi=100, div_by_zero=1. A following MULTU 3×3 → lo=9, div_by_zero=0.
- start pulsed with new operands at cycle 10 of a busy MULTU 20×30 → result 600. No second done appears.
- reset asserted mid-RUN → all outputs 0 immediately, without waiting for a clock edge. A fresh MULTU 1000×1000 afterwards → lo=1000000, with full latency.
